// File: rtl/outpass_n_pipe_config_mux.sv
// Configurable per-channel output pass: bypass, 1-stage, 2-stage or rising-edge pulse.
// Each channel owns a two-stage shift register; the mode only picks which tap reaches O.

// 2:1 multiplexer cell used to build the output select tree.
module cus_mux21 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);
  assign X = S ? A1 : A0;
endmodule

module outpass_n_pipe_config_mux #(
  parameter int unsigned       WIDTH        = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
  parameter int unsigned       NoConfigBits = 2 * WIDTH
) (
  input  logic                    UserCLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        I,
  input  logic                    CE,
  output logic [WIDTH-1:0]        O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;
  logic [WIDTH-1:0] pulse;

  // Next-state: shift I -> Q1 -> Q2 when enabled, otherwise hold.
  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    if (CE) begin
      q1_d = I;
      q2_d = q1_q;
    end
  end

  // Both stages load RESET_VALUE asynchronously, regardless of clock or enable.
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      q1_q <= RESET_VALUE;
      q2_q <= RESET_VALUE;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign pulse = q1_q & ~q2_q;

  // Per-channel mode select: bit 0 picks within each pair, bit 1 picks the pair.
  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    logic sel_lo;
    logic sel_hi;

    cus_mux21 u_mux_lo (
      .A0 (I[g]),
      .A1 (q1_q[g]),
      .S  (ConfigBits[2*g]),
      .X  (sel_lo)
    );

    cus_mux21 u_mux_hi (
      .A0 (q2_q[g]),
      .A1 (pulse[g]),
      .S  (ConfigBits[2*g]),
      .X  (sel_hi)
    );

    cus_mux21 u_mux_out (
      .A0 (sel_lo),
      .A1 (sel_hi),
      .S  (ConfigBits[2*g+1]),
      .X  (O[g])
    );
  end

endmodule

// File: tb/tb_outpass_n_pipe_config_mux.sv
// Scoreboard bench for outpass_n_pipe_config_mux: a 4-channel and an 8-channel instance
// driven side by side, checked against a history-based reference model.
module tb_outpass_n_pipe_config_mux;

  localparam logic [3:0] RV4 = 4'b1010;
  localparam logic [7:0] RV8 = 8'h5C;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [3:0]  i4;
  logic [7:0]  cfg4;
  logic [3:0]  o4;
  logic [7:0]  i8;
  logic [15:0] cfg8;
  logic [7:0]  o8;

  outpass_n_pipe_config_mux #(.WIDTH(4), .RESET_VALUE(RV4), .NoConfigBits(8)) dut4 (
    .UserCLK    (clk),
    .RESET      (rst),
    .I          (i4),
    .CE         (ce),
    .O          (o4),
    .ConfigBits (cfg4)
  );

  outpass_n_pipe_config_mux #(.WIDTH(8), .RESET_VALUE(RV8), .NoConfigBits(16)) dut8 (
    .UserCLK    (clk),
    .RESET      (rst),
    .I          (i8),
    .CE         (ce),
    .O          (o8),
    .ConfigBits (cfg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] e4;
    logic [7:0] e8;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: the input seen at the most recent enabled edge and the one before it.
  logic [7:0] last4, prev4, last8, prev8;

  function automatic logic [7:0] model_out(input logic [15:0] cfg, input logic [7:0] in,
                                           input logic [7:0] last, input logic [7:0] prev,
                                           input int n);
    logic [7:0] r;
    logic [1:0] m;
    r = '0;
    for (int c = 0; c < n; c++) begin
      m = cfg[2*c +: 2];
      case (m)
        2'd0:    r[c] = in[c];
        2'd1:    r[c] = last[c];
        2'd2:    r[c] = prev[c];
        default: r[c] = last[c] & ~prev[c];
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    last4 = 8'(RV4); prev4 = 8'(RV4);
    last8 = RV8;     prev8 = RV8;
  endtask

  task automatic push_expect(input string name);
    exp_t e;
    e.e4   = 4'(model_out({8'h00, cfg4}, 8'(i4), last4, prev4, 4));
    e.e8   = model_out(cfg8, i8, last8, prev8, 8);
    e.name = name;
    sb.push_back(e);
  endtask

  // One cycle: account for the edge just taken, then apply new inputs and predict O.
  task automatic step(input logic n_rst, input logic n_ce, input logic [3:0] n_i4,
                      input logic [7:0] n_cfg4, input logic [7:0] n_i8,
                      input logic [15:0] n_cfg8, input string name);
    @(posedge clk);
    if (rst) model_reset();
    else if (ce) begin
      prev4 = last4; last4 = 8'(i4);
      prev8 = last8; last8 = i8;
    end
    #1;
    rst = n_rst; ce = n_ce; i4 = n_i4; cfg4 = n_cfg4; i8 = n_i8; cfg8 = n_cfg8;
    if (n_rst) model_reset();
    push_expect(name);
  endtask

  // Monitor: O is valid every cycle, compared mid-cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (o4 !== e.e4) begin
          n_fail++;
          $display("FAIL %s w4: got %b expected %b", e.name, o4, e.e4);
        end
        n_checks++;
        if (o8 !== e.e8) begin
          n_fail++;
          $display("FAIL %s w8: got %b expected %b", e.name, o8, e.e8);
        end
      end
    end
  end

  initial begin
    logic [3:0]  pat[3];
    logic [7:0]  c4;
    logic [15:0] c8;
    rst = 1'b1; ce = 1'b0; i4 = '0; cfg4 = 8'h55; i8 = '0; cfg8 = 16'h5555;
    model_reset();

    // Power-on reset, then fill registers, then a mid-cycle reset pulse with mixed modes.
    step(1'b1, 1'b0, 4'h0, 8'b11_00_10_01, 8'h00, 16'h5555, "por");
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b1, 4'($urandom), 8'b11_00_10_01, 8'($urandom), 16'h5555, "prefill");
    step(1'b1, 1'b1, 4'h7, 8'b11_00_10_01, 8'h3C, 16'hFFFF, "rst_mid");
    step(1'b0, 1'b1, 4'h7, 8'b11_00_10_01, 8'h3C, 16'hFFFF, "rst_rel");
    step(1'b0, 1'b1, 4'h7, 8'b11_00_10_01, 8'h3C, 16'hFFFF, "rst_rel2");

    // Single- and double-registered sequences 0x3, 0x5, 0xC.
    pat[0] = 4'h3; pat[1] = 4'h5; pat[2] = 4'hC;
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b1, (k < 3) ? pat[k] : 4'h0, 8'h55, 8'($urandom), 16'h5555, "mode01_seq");
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b1, (k < 3) ? pat[k] : 4'h0, 8'hAA, 8'($urandom), 16'hAAAA, "mode10_seq");

    // Rising-edge pulse on channel 0: low, high for 5, back low.
    for (int k = 0; k < 10; k++)
      step(1'b0, 1'b1, (k >= 2 && k < 7) ? 4'h1 : 4'h0, 8'h03, 8'($urandom), 16'hFFFF, "pulse");

    // Clock enable held low while I changes, then released.
    step(1'b0, 1'b1, 4'h0, 8'h55, 8'h00, 16'h5555, "ce_pre");
    step(1'b0, 1'b1, 4'h0, 8'h55, 8'h00, 16'h5555, "ce_pre2");
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 4'hF, 8'h55, 8'hFF, 16'h5555, "ce_hold");
    step(1'b0, 1'b1, 4'hF, 8'h55, 8'hFF, 16'h5555, "ce_go");
    step(1'b0, 1'b1, 4'hF, 8'h55, 8'hFF, 16'h5555, "ce_go2");

    // Bypass channel 2 while reset is held and enable is low.
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, 4'($urandom), 8'b01_00_10_11, 8'($urandom), 16'h0000, "bypass_rst");
    step(1'b0, 1'b1, 4'h0, 8'h55, 8'h00, 16'h5555, "bypass_rel");

    // Channel 5 of the wide instance switches 01 -> 10 with Q1=1, Q2=0.
    step(1'b0, 1'b1, 4'h0, 8'h55, 8'h00, 16'h5555, "sw_a");
    step(1'b0, 1'b1, 4'h0, 8'h55, 8'h20, 16'h5555, "sw_b");
    step(1'b0, 1'b0, 4'h0, 8'h55, 8'h20, 16'h5555, "sw_c");
    step(1'b0, 1'b0, 4'h0, 8'h55, 8'h20, 16'h5955, "sw_switch");
    step(1'b0, 1'b0, 4'h0, 8'h55, 8'h20, 16'h5955, "sw_hold");

    // Randomised traffic with occasional resets, enable gaps and mode changes.
    c4 = 8'($urandom); c8 = 16'($urandom);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) c4 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) c8 = 16'($urandom);
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 4'($urandom),
           c4, 8'($urandom), c8, "random");
    end

    // Let the monitor drain the last prediction.
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/outpass_n_pipe_config_mux.md
Name: outpass_n_pipe_config_mux

Overview:
- Parametrised successor of the fixed 4-bit output pass BEL, generalised to WIDTH channels.
- Each channel independently selects one of four modes: combinational bypass, 1-stage registered, 2-stage registered, or rising-edge pulse.
- Registers have a fabric-driven clock enable and an asynchronous reset.
- Sits in the RAM_IO tile, between the switch matrix outputs and EXTERNAL pins driven to the fabric top.

Parameters:
- WIDTH, 4, number of independent channels (1..32).
- RESET_VALUE, {WIDTH{1'b0}}, per-channel reset value loaded into both register stages.
- NoConfigBits, 2*WIDTH, config bits (2 per channel); set manually, not derived.

Ports:
- UserCLK  input  1  user clock; EXTERNAL, SHARED_PORT.
- RESET  input  1  asynchronous, active-high reset of all channel registers; EXTERNAL, SHARED_PORT.
- I  input  WIDTH  channel data from switch matrix.
- CE  input  1  register clock enable from switch matrix; 1 = registers update.
- O  output  WIDTH  channel outputs; EXTERNAL.
- ConfigBits  input  NoConfigBits  GLOBAL; channel n mode = ConfigBits[2n+1:2n].

Behaviour:
- Per channel n: two registers, Q1[n] and Q2[n].
  - On posedge UserCLK with CE=1: Q1[n] <= I[n]; Q2[n] <= Q1[n].
  - CE=0: both hold.
- RESET=1 (asynchronous, immediate, independent of clock/CE): Q1 = Q2 = RESET_VALUE.
- Registers run in every mode; mode only selects the output.
- Mode decode, combinational from Q1/Q2/I, built from cus_mux21 cells (no behavioural mux on the output path):
  - 00 bypass: O[n] = I[n]; latency 0; unaffected by RESET and CE.
  - 01 registered: O[n] = Q1[n]; latency 1 enabled edge.
  - 10 double-registered: O[n] = Q2[n]; latency 2 enabled edges; usable as 2-flop synchroniser.
  - 11 rising-edge pulse: O[n] = Q1[n] & ~Q2[n].
    - High for exactly one enabled cycle after I[n] goes 0->1.
    - With CE held low the pulse level holds.
- Output reset values:
  - Modes 01/10: RESET_VALUE[n].
  - Mode 11: 0, since Q1 == Q2 under reset.
  - Mode 00: follows I.
- Reset mid-operation: in-flight data in Q1/Q2 is discarded. First post-reset enabled edge loads I into Q1 while Q2 takes RESET_VALUE.
  - Mode 11 with RESET_VALUE[n]=0 and I[n]=1 held across reset: one pulse after release.
- ConfigBits change at runtime: output reselects combinationally in the same cycle; register contents unaffected.
- No cross-channel interaction; channels share only UserCLK, RESET and CE.

Test Plan:
- WIDTH=4, RESET_VALUE=4'b1010, RESET pulsed mid-cycle (no clock edge) -> modes 01/10 outputs go to 1,0,1,0 immediately; mode 11 channels = 0; mode 00 channel tracks I.
- All modes 01, CE=1, I sequence 0x3,0x5,0xC on successive edges -> O = 0x3,0x5,0xC each one edge later. Mode 10 -> same sequence two edges later.
- Mode 11 on channel 0, I[0] 0->1 held high 5 cycles -> O[0] high exactly 1 cycle; I[0] 1->0 -> O[0] stays 0.
- Mode 01, CE=0 for 3 edges while I changes 0x0->0xF -> O holds 0x0. CE=1 -> O = 0xF after next edge.
- Mode 00 on channel 2 with RESET asserted and CE=0 -> O[2] follows I[2] combinationally.
- WIDTH=8: switch channel 5 mode 01->10 mid-stream with Q1=1, Q2=0 -> O[5] changes 1->0 the same cycle, without waiting for a clock edge; other channels unchanged.
